// File: rtl/climate_pkg.sv
// Shared state encoding and sensor code constants for the multi-zone climate controller.
package climate_pkg;

  typedef enum logic [1:0] {IDLE, HEAT, COOL, FAULT} zone_state_t;

  localparam logic [1:0] CODE_COLD = 2'b00;
  localparam logic [1:0] CODE_INV  = 2'b01;
  localparam logic [1:0] CODE_OK   = 2'b10;
  localparam logic [1:0] CODE_HOT  = 2'b11;

endpackage

// File: rtl/zone_debounce.sv
// Per-zone sensor sampler and debouncer: a new code must hold DEB cycles in s_q
// before it is accepted as the stable code.
module zone_debounce
  import climate_pkg::*;
#(
  parameter int DEB = 4,
  parameter int CW  = 3
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] raw,
  output logic [1:0] stable
);

  logic [1:0]    s_q;
  logic [1:0]    cand;
  logic [CW-1:0] deb_cnt;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      s_q     <= CODE_OK;
      cand    <= CODE_OK;
      stable  <= CODE_OK;
      deb_cnt <= '0;
    end else begin
      s_q <= raw;
      // A return to the accepted code cancels any pending candidate count.
      if (s_q == stable) begin
        deb_cnt <= '0;
      end else if (s_q != cand) begin
        cand    <= s_q;
        deb_cnt <= CW'(1);
      end else if (deb_cnt == CW'(DEB - 1)) begin
        stable  <= cand;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/climate_zone_ctrl.sv
// Multi-zone thermostat: debounced sensor codes drive a per-zone HEAT/COOL/FAULT
// state machine with a minimum run time and a latched fault cleared by fault_clr.
module climate_zone_ctrl
  import climate_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DEB     = 4,
  parameter int MIN_RUN = 8
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [2*NCH-1:0] sens,
  input  logic             fault_clr,
  output logic [NCH-1:0]   heat,
  output logic [NCH-1:0]   cool,
  output logic [NCH-1:0]   fault,
  output logic             alarm
);

  localparam int CW = $clog2((DEB > MIN_RUN) ? DEB : MIN_RUN) + 1;

  for (genvar i = 0; i < NCH; i++) begin : g_zone
    logic [1:0]    stable;
    zone_state_t   state;
    zone_state_t   state_nxt;
    logic [CW-1:0] run_cnt;

    zone_debounce #(
      .DEB (DEB),
      .CW  (CW)
    ) u_deb (
      .clk_2  (clk_2),
      .reset  (reset),
      .raw    (sens[2*i+1:2*i]),
      .stable (stable)
    );

    // An invalid code overrides everything, including an unexpired minimum run.
    always_comb begin
      state_nxt = state;
      if (stable == CODE_INV) begin
        state_nxt = FAULT;
      end else begin
        case (state)
          IDLE:  if (stable == CODE_COLD)     state_nxt = HEAT;
                 else if (stable == CODE_HOT) state_nxt = COOL;
          HEAT:  if (stable != CODE_COLD && run_cnt == '0) state_nxt = IDLE;
          COOL:  if (stable != CODE_HOT && run_cnt == '0)  state_nxt = IDLE;
          FAULT: if (fault_clr)               state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_2) begin
      if (reset) begin
        state   <= IDLE;
        run_cnt <= '0;
      end else begin
        state <= state_nxt;
        if ((state_nxt == HEAT && state != HEAT) || (state_nxt == COOL && state != COOL))
          run_cnt <= CW'(MIN_RUN - 1);
        else if (run_cnt != '0)
          run_cnt <= run_cnt - CW'(1);
      end
    end

    assign heat[i]  = (state == HEAT);
    assign cool[i]  = (state == COOL);
    assign fault[i] = (state == FAULT);
  end

  assign alarm = |fault;

endmodule

// File: tb/tb_climate_zone_ctrl.sv
// Directed bench for climate_zone_ctrl with NCH=2, DEB=4, MIN_RUN=8.
module tb_climate_zone_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sens  = 4'b1010;
  logic       fault_clr = 1'b0;
  logic [1:0] heat, cool, fault;
  logic       alarm;

  int checks = 0;
  int failures = 0;

  climate_zone_ctrl #(.NCH(2), .DEB(4), .MIN_RUN(8)) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .sens      (sens),
    .fault_clr (fault_clr),
    .heat      (heat),
    .cool      (cool),
    .fault     (fault),
    .alarm     (alarm)
  );

  always #5 clk_2 = ~clk_2;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_2);
      #1;
    end
  endtask

  task automatic set_zone(input int z, input logic [1:0] c);
    sens[2*z +: 2] = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sens = 4'b1010;
    fault_clr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (heat !== 2'b00) begin failures++; $display("FAIL reset_heat got=%b exp=00", heat); end
    checks++;
    if (cool !== 2'b00) begin failures++; $display("FAIL reset_cool got=%b exp=00", cool); end
    checks++;
    if (fault !== 2'b00 || alarm !== 1'b0) begin
      failures++; $display("FAIL reset_fault got=%b/%b exp=00/0", fault, alarm);
    end
  endtask

  task automatic test_heat_entry();
    do_reset();
    set_zone(0, 2'b00);
    tick(5);  // edges 0..4
    checks++;
    if (heat !== 2'b00) begin failures++; $display("FAIL heat_early edge4 got=%b exp=00", heat); end
    tick(1);  // edge 5
    checks++;
    if (heat !== 2'b01) begin failures++; $display("FAIL heat_entry edge5 got=%b exp=01", heat); end
    checks++;
    if (cool !== 2'b00 || fault !== 2'b00) begin
      failures++; $display("FAIL heat_entry_others cool=%b fault=%b exp=00/00", cool, fault);
    end
  endtask

  task automatic test_glitch();
    logic bad;
    do_reset();
    set_zone(0, 2'b00);
    tick(3);
    set_zone(0, 2'b10);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (heat !== 2'b00 || cool !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL glitch_ignored got=1 exp=0 heat=%b", heat); end
    // A fresh code must still need the full debounce after the aborted one.
    set_zone(0, 2'b00);
    tick(5);
    checks++;
    if (heat !== 2'b00) begin failures++; $display("FAIL glitch_then_early got=%b exp=00", heat); end
    tick(1);
    checks++;
    if (heat !== 2'b01) begin failures++; $display("FAIL glitch_then_heat got=%b exp=01", heat); end
  endtask

  task automatic test_min_run();
    do_reset();
    set_zone(0, 2'b00);
    tick(6);  // heat entered at edge 5
    set_zone(0, 2'b10);
    for (int e = 6; e <= 12; e++) begin
      tick(1);
      checks++;
      if (heat[0] !== 1'b1) begin failures++; $display("FAIL min_run_hold edge%0d got=%b exp=1", e, heat[0]); end
    end
    tick(1);  // edge 13
    checks++;
    if (heat[0] !== 1'b0) begin failures++; $display("FAIL min_run_drop edge13 got=%b exp=0", heat[0]); end
  endtask

  task automatic test_fault();
    do_reset();
    set_zone(1, 2'b11);
    tick(6);
    checks++;
    if (cool !== 2'b10) begin failures++; $display("FAIL fault_pre_cool got=%b exp=10", cool); end
    set_zone(1, 2'b01);
    tick(5);
    checks++;
    if (cool !== 2'b10 || fault !== 2'b00) begin
      failures++; $display("FAIL fault_early cool=%b fault=%b exp=10/00", cool, fault);
    end
    tick(1);
    checks++;
    if (fault !== 2'b10 || cool !== 2'b00 || alarm !== 1'b1) begin
      failures++; $display("FAIL fault_latch fault=%b cool=%b alarm=%b exp=10/00/1", fault, cool, alarm);
    end
    fault_clr = 1'b1;
    tick(3);
    checks++;
    if (fault !== 2'b10 || alarm !== 1'b1) begin
      failures++; $display("FAIL fault_clr_blocked fault=%b alarm=%b exp=10/1", fault, alarm);
    end
    fault_clr = 1'b0;
    set_zone(1, 2'b10);
    tick(5);
    checks++;
    if (fault !== 2'b10) begin failures++; $display("FAIL fault_held_noclr got=%b exp=10", fault); end
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++;
    if (fault !== 2'b00 || alarm !== 1'b0 || heat !== 2'b00 || cool !== 2'b00) begin
      failures++; $display("FAIL fault_clear fault=%b alarm=%b heat=%b cool=%b exp=00/0/00/00", fault, alarm, heat, cool);
    end
  endtask

  task automatic test_heat_to_cool();
    logic exp_h, exp_c;
    do_reset();
    set_zone(0, 2'b00);
    tick(6);
    set_zone(0, 2'b11);
    for (int e = 6; e <= 17; e++) begin
      tick(1);
      exp_h = (e <= 12);
      exp_c = (e >= 14);
      checks++;
      if (heat[0] !== exp_h || cool[0] !== exp_c) begin
        failures++;
        $display("FAIL heat_to_cool edge%0d heat=%b cool=%b exp=%b/%b", e, heat[0], cool[0], exp_h, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_c0, exp_h1;
    do_reset();
    set_zone(0, 2'b00);
    set_zone(1, 2'b11);
    tick(6);
    checks++;
    if (heat !== 2'b01 || cool !== 2'b10) begin
      failures++; $display("FAIL reset_mid_pre heat=%b cool=%b exp=01/10", heat, cool);
    end
    set_zone(0, 2'b11);
    set_zone(1, 2'b00);
    tick(3);
    reset = 1'b1;
    tick(1);
    checks++;
    if (heat !== 2'b00 || cool !== 2'b00 || fault !== 2'b00 || alarm !== 1'b0) begin
      failures++; $display("FAIL reset_mid heat=%b cool=%b fault=%b alarm=%b exp=00/00/00/0", heat, cool, fault, alarm);
    end
    reset = 1'b0;
    for (int e = 0; e <= 5; e++) begin
      tick(1);
      exp_c0 = (e == 5);
      exp_h1 = (e == 5);
      checks++;
      if (cool[0] !== exp_c0 || heat[1] !== exp_h1 || heat[0] !== 1'b0 || cool[1] !== 1'b0) begin
        failures++;
        $display("FAIL reset_fresh_deb edge%0d heat=%b cool=%b exp_cool0=%b exp_heat1=%b", e, heat, cool, exp_c0, exp_h1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_heat_entry();
    test_glitch();
    test_min_run();
    test_fault();
    test_heat_to_cool();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
